// File: rtl/ppu_vram_ctrl_if.sv
// PPU VRAM controller bus bundle: render fetch port, CPU register port,
// control levels and the cartridge CHR bus.
interface ppu_vram_ctrl_if;
    logic [13:0] ren_a_in;
    logic        ren_rd_in;
    logic [7:0]  ren_d_out;
    logic        cpu_sel_in;
    logic [2:0]  cpu_a_in;
    logic        cpu_wr_in;
    logic [7:0]  cpu_d_in;
    logic [7:0]  cpu_d_out;
    logic        cpu_rdy_out;
    logic        w_clr_in;
    logic        inc32_in;
    logic        mirror_v_in;
    logic [12:0] chr_a_out;
    logic        chr_rd_out;
    logic        chr_wr_out;
    logic [7:0]  chr_d_out;
    logic [7:0]  chr_d_in;

    modport slave (
        input  ren_a_in, ren_rd_in, cpu_sel_in, cpu_a_in, cpu_wr_in, cpu_d_in,
        input  w_clr_in, inc32_in, mirror_v_in, chr_d_in,
        output ren_d_out, cpu_d_out, cpu_rdy_out,
        output chr_a_out, chr_rd_out, chr_wr_out, chr_d_out
    );

    modport master (
        output ren_a_in, ren_rd_in, cpu_sel_in, cpu_a_in, cpu_wr_in, cpu_d_in,
        output w_clr_in, inc32_in, mirror_v_in, chr_d_in,
        input  ren_d_out, cpu_d_out, cpu_rdy_out,
        input  chr_a_out, chr_rd_out, chr_wr_out, chr_d_out
    );
endinterface

// File: rtl/ppu_vram_ctrl.sv
// PPU VRAM arbiter: render fetches have absolute priority; CPU PPUADDR/PPUDATA
// accesses wait in PEND until the array and CHR bus are free.
module ppu_vram_ctrl #(
    parameter int NT_AW = 11
) (
    input logic             clk_in,
    input logic             rst_in,
    ppu_vram_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_PEND, ST_EXEC} state_e;

    state_e      st_q;
    logic [13:0] v_q;
    logic [13:0] t_q;
    logic        w_q;
    logic        vcopy_q;
    logic        op_wr_q;
    logic [7:0]  rbuf_q;
    logic [7:0]  ren_d_q;
    logic [7:0]  cpu_d_q;

    logic [7:0]  nt_mem [2**NT_AW];
    logic [5:0]  pal_mem [32];

    logic             addr_wr;
    logic             data_stb;
    logic             exec_go;
    logic [13:0]      sel_a;
    logic             is_chr;
    logic             is_pal;
    logic [NT_AW-1:0] nt_idx;
    logic [4:0]       pal_idx;
    logic [7:0]       nt_rd;
    logic [5:0]       pal_rd;
    logic [7:0]       rd_data;

    always_comb begin
        addr_wr  = bus.cpu_sel_in && bus.cpu_wr_in && (bus.cpu_a_in == 3'd6);
        data_stb = bus.cpu_sel_in && (bus.cpu_a_in == 3'd7);
        exec_go  = (st_q == ST_EXEC) && !bus.ren_rd_in;
        sel_a    = bus.ren_rd_in ? bus.ren_a_in : v_q;
        is_chr   = !sel_a[13];
        is_pal   = (sel_a[13:8] == 6'h3F);
        // Palette reads also index the nametable here: 0x3Fxx maps onto the 0x2Fxx mirror.
        if (NT_AW >= 12) begin
            nt_idx = NT_AW'(sel_a[11:0]);
        end else begin
            nt_idx = NT_AW'({bus.mirror_v_in ? sel_a[10] : sel_a[11], sel_a[9:0]});
        end
        pal_idx = (sel_a[4] && (sel_a[1:0] == 2'b00)) ? {1'b0, sel_a[3:0]} : sel_a[4:0];
        nt_rd   = nt_mem[nt_idx];
        pal_rd  = pal_mem[pal_idx];
        if (is_chr) begin
            rd_data = bus.chr_d_in;
        end else if (is_pal) begin
            rd_data = {2'b00, pal_rd};
        end else begin
            rd_data = nt_rd;
        end
    end

    assign bus.chr_a_out   = sel_a[12:0];
    assign bus.chr_d_out   = bus.cpu_d_in;
    assign bus.chr_rd_out  = rst_in && is_chr && (bus.ren_rd_in || (exec_go && !op_wr_q));
    assign bus.chr_wr_out  = is_chr && exec_go && op_wr_q;
    assign bus.cpu_rdy_out = exec_go;
    assign bus.ren_d_out   = ren_d_q;
    assign bus.cpu_d_out   = cpu_d_q;

    always_ff @(posedge clk_in) begin
        if (exec_go && op_wr_q) begin
            if (is_pal) begin
                pal_mem[pal_idx] <= bus.cpu_d_in[5:0];
            end else if (!is_chr) begin
                nt_mem[nt_idx] <= bus.cpu_d_in;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            st_q    <= ST_IDLE;
            v_q     <= '0;
            t_q     <= '0;
            w_q     <= 1'b0;
            vcopy_q <= 1'b0;
            op_wr_q <= 1'b0;
            rbuf_q  <= '0;
            ren_d_q <= '0;
            cpu_d_q <= '0;
        end else begin
            if (bus.ren_rd_in) begin
                ren_d_q <= rd_data;
            end

            w_q <= bus.w_clr_in ? 1'b0 : (addr_wr ? !w_q : w_q);
            if (addr_wr) begin
                if (!w_q) begin
                    t_q[13:8] <= bus.cpu_d_in[5:0];
                end else begin
                    t_q[7:0] <= bus.cpu_d_in;
                end
            end

            case (st_q)
                ST_IDLE: begin
                    if (data_stb) begin
                        st_q    <= ST_PEND;
                        op_wr_q <= bus.cpu_wr_in;
                    end
                end
                ST_PEND: begin
                    if (!bus.ren_rd_in) begin
                        st_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (exec_go) begin
                        st_q <= ST_IDLE;
                        v_q  <= v_q + (bus.inc32_in ? 14'd32 : 14'd1);
                        if (!op_wr_q) begin
                            if (is_pal) begin
                                cpu_d_q <= {2'b00, pal_rd};
                                rbuf_q  <= nt_rd;
                            end else begin
                                cpu_d_q <= rbuf_q;
                                rbuf_q  <= rd_data;
                            end
                        end
                    end
                end
                default: st_q <= ST_IDLE;
            endcase

            // A second PPUADDR byte during an access only updates t; v follows once back in IDLE.
            if (addr_wr && w_q && (st_q == ST_IDLE)) begin
                v_q     <= {t_q[13:8], bus.cpu_d_in};
                vcopy_q <= 1'b0;
            end else if (addr_wr && w_q) begin
                vcopy_q <= 1'b1;
            end else if (vcopy_q && (st_q == ST_IDLE)) begin
                v_q     <= t_q;
                vcopy_q <= 1'b0;
            end
        end
    end
endmodule

// File: doc/ppu_vram_ctrl.md
PPU_VRAM_CTRL -- requirements
Module: ppu_vram_ctrl

Interface
REQ-001 SHALL have parameter NT_AW, default 11, nametable RAM address width (11 = 2 KB mirrored; 12 = 4 KB four-screen, mirroring ignored).
REQ-002 SHALL have port clk_in  input  1  system clock; one clock domain.
REQ-003 SHALL have port rst_in  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port ren_a_in  input  14  render-side PPU address (background/sprite fetch).
REQ-005 SHALL have port ren_rd_in  input  1  render read request, level, sampled every clk.
REQ-006 SHALL have port ren_d_out  output  8  render read data.
REQ-007 SHALL have port cpu_sel_in  input  1  one-cycle CPU register strobe.
REQ-008 SHALL have port cpu_a_in  input  3  register index; only 6 (PPUADDR) and 7 (PPUDATA) decoded.
REQ-009 SHALL have port cpu_wr_in  input  1  1 = write, 0 = read; qualified by cpu_sel_in.
REQ-010 SHALL have port cpu_d_in  input  8  CPU write data.
REQ-011 SHALL have port cpu_d_out  output  8  PPUDATA read result.
REQ-012 SHALL have port cpu_rdy_out  output  1  one-cycle pulse when a PPUDATA access completes.
REQ-013 SHALL have port w_clr_in  input  1  clears the PPUADDR write toggle (PPUSTATUS read).
REQ-014 SHALL have port inc32_in  input  1  PPUDATA increment select: 0 = +1, 1 = +32.
REQ-015 SHALL have port mirror_v_in  input  1  1 = vertical mirroring, 0 = horizontal.
REQ-016 SHALL have ports chr_a_out output 13, chr_rd_out output 1, chr_wr_out output 1, chr_d_out output 8, chr_d_in input 8: cartridge CHR bus, same-cycle combinational read data.

Function
REQ-017 Address map SHALL be: 0x0000-0x1FFF CHR; 0x2000-0x3EFF nametable (0x3000+ mirrors 0x2000+); 0x3F00-0x3FFF palette, index = a[4:0].
REQ-018 Nametable index SHALL be {a[10], a[9:0]} when mirror_v_in=1, {a[11], a[9:0]} when 0; NT_AW=12 uses a[11:0].
REQ-019 Palette indices 0x10/0x14/0x18/0x1C SHALL alias 0x00/0x04/0x08/0x0C for reads and writes; palette entries 6 bits, read back with bits 7:6 = 0.
REQ-020 Render read: ren_rd_in high at edge N SHALL load ren_d_out with data at ren_a_in by edge N+1 (latency 1 clk); ren_d_out holds until next render read.
REQ-021 Render port SHALL have absolute priority; in any cycle with ren_rd_in=1 the array/CHR bus serves only the render address.
REQ-022 PPUADDR write SHALL load t[13:8] = cpu_d_in[5:0] when toggle w=0, else t[7:0] = cpu_d_in and copy t into v; w inverts on each PPUADDR write; w_clr_in forces w=0 (w_clr_in wins over simultaneous write toggle).
REQ-023 PPUDATA access SHALL use FSM IDLE -> PEND on strobe; PEND -> EXEC on first clk with ren_rd_in=0; EXEC -> IDLE with cpu_rdy_out=1 for that cycle.
REQ-024 EXEC write SHALL store cpu_d_in at v (CHR via chr_wr_out=1 one cycle, nametable, or palette).
REQ-025 EXEC read for v < 0x3F00 SHALL output the old read buffer on cpu_d_out and load buffer with data at v; for v >= 0x3F00 SHALL output palette data directly and load buffer with nametable data at v - 0x1000.
REQ-026 On EXEC, v SHALL increment by 1 or 32 per inc32_in sampled in EXEC, wrapping modulo 2^14.
REQ-027 PPUDATA strobe while not IDLE SHALL be ignored; PPUADDR write while not IDLE SHALL update t/w, and v only after the pending access completes (v copy deferred one cycle past EXEC).
REQ-028 cpu_d_out SHALL hold its value until the next EXEC read.
REQ-029 chr_rd_out SHALL be high only in cycles serving a CHR-range read; chr_a_out = selected address[12:0]; chr_d_out = cpu_d_in.

Reset
REQ-030 rst_in low SHALL immediately force: FSM IDLE, v=t=0, w=0, read buffer 0, ren_d_out=0, cpu_d_out=0, cpu_rdy_out=0, chr_rd_out=0, chr_wr_out=0.
REQ-031 A pending or executing PPUDATA access SHALL be discarded by reset with no write performed; nametable and palette contents need not be reset.

Verification
REQ-032 mirror_v_in=1, CPU writes 0xAB to 0x2005 -> render read 0x2805 returns 0xAB one clk later; 0x2405 does not; with mirror_v_in=0, 0x2405 returns 0xAB.
REQ-033 PPUADDR 0x21,0x00, PPUDATA read twice -> first cpu_d_out = prior buffer, second = byte at 0x2100; v = 0x2102.
REQ-034 Write 0x3F10 = 0x2A, read 0x3F00 -> cpu_d_out = 0x2A immediately, buffer = nametable at 0x2F00.
REQ-035 ren_rd_in held high 5 clks with PPUDATA write pending -> cpu_rdy_out and chr_wr_out/array write occur on clk 6 only.
REQ-036 inc32_in=1, v=0x3FF0, PPUDATA write -> v = 0x0010; rst_in low during PEND -> no write, rdy never pulses, v = 0.
